// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the RAM arbiter: address/data
//            widths, requester ownership IDs and arbiter states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

    localparam int c_addr_width = 10;
    localparam int c_data_width = 16;

    // Identifies which requester owns the RAM in a given cycle.
    typedef enum logic [1:0] {
        OWN_BOOT = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2,
        OWN_NONE = 2'd3
    } mem_owner_t;

    typedef enum logic [1:0] {
        ARB_BOOT   = 2'd0,
        ARB_SHARED = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
// ============================================================================
// Module   : rr_pick2
// Purpose  : Two-input round-robin picker. req0/req1 compete; the internal
//            pointer remembers the most recent winner so the other input wins
//            the next contention. A lone requester always wins.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            req0, req1      - requests (already masked by the caller)
//            gnt0, gnt1      - one-hot (or zero) grants, combinational
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    // 1 = input 1 won most recently, so input 0 has priority next.
    // Resets to 1 so input 0 takes the first contention.
    logic r_last;

    assign gnt0 = req0 & (~req1 | r_last);
    assign gnt1 = req1 & (~req0 | ~r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (gnt0 | gnt1) begin
            r_last <= gnt1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares a 1024x16 synchronous single-port RAM between the boot
//            loader, the evaluator core and the debug reader. Drives the RAM
//            address/we/wdata mux from the current winner and steers the
//            registered read data back to the owner one cycle later. The core
//            can lock the RAM for multi-access sequences, bounded by LOCK_MAX.
// Ports    : clk, rst                          - clock, async active-high reset
//            boot_active/req/we/addr/wdata/gnt - boot loader port
//            core_req/we/lock/addr/wdata       - core request port
//            core_gnt, core_rvalid             - core grant / read valid
//            dbg_req/addr, dbg_gnt/rvalid      - debug read-only port
//            rdata                             - read data, qualified by rvalid
//            ram_we/addr/wdata, ram_rdata      - RAM side
//            lock_err                          - sticky lock-timeout flag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit BYPASS_BOOT = 1'b0,
    parameter int LOCK_MAX    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    boot_active,
    input  logic                    boot_req,
    input  logic                    boot_we,
    input  logic [c_addr_width-1:0] boot_addr,
    input  logic [c_data_width-1:0] boot_wdata,
    output logic                    boot_gnt,
    input  logic                    core_req,
    input  logic                    core_we,
    input  logic                    core_lock,
    input  logic [c_addr_width-1:0] core_addr,
    input  logic [c_data_width-1:0] core_wdata,
    output logic                    core_gnt,
    output logic                    core_rvalid,
    input  logic                    dbg_req,
    input  logic [c_addr_width-1:0] dbg_addr,
    output logic                    dbg_gnt,
    output logic                    dbg_rvalid,
    output logic [c_data_width-1:0] rdata,
    output logic                    ram_we,
    output logic [c_addr_width-1:0] ram_addr,
    output logic [c_data_width-1:0] ram_wdata,
    input  logic [c_data_width-1:0] ram_rdata,
    output logic                    lock_err
);

    localparam int c_cnt_w = $clog2(LOCK_MAX + 1);

    arb_state_t              r_state;
    logic [c_cnt_w-1:0]      r_lock_cnt;
    logic                    r_lock_err;
    logic                    r_mask_core;   // one-cycle core mask after a forced release
    mem_owner_t              r_rd_owner;    // owner of the read issued last cycle
    logic [c_addr_width-1:0] r_addr_hold;   // RAM address when nobody is granted

    logic       w_boot_gnt;
    logic       w_core_req_eff;
    logic       w_dbg_req_eff;
    logic       w_core_gnt;
    logic       w_dbg_gnt;
    mem_owner_t w_owner;

    // Per-state request qualification; reset blocks every grant.
    always_comb begin
        w_boot_gnt     = 1'b0;
        w_core_req_eff = 1'b0;
        w_dbg_req_eff  = 1'b0;
        if (!rst) begin
            case (r_state)
                ARB_BOOT:   w_boot_gnt = boot_req & ~BYPASS_BOOT;
                ARB_SHARED: begin
                    w_core_req_eff = core_req & ~r_mask_core;
                    w_dbg_req_eff  = dbg_req;
                end
                ARB_LOCKED: w_core_req_eff = core_req;
                default:    ;
            endcase
        end
    end

    // Locked state feeds only the core request, so the picker's pointer
    // still tracks every core/debug winner.
    rr_pick2 u_pick (
        .clk  (clk),
        .rst  (rst),
        .req0 (w_core_req_eff),
        .req1 (w_dbg_req_eff),
        .gnt0 (w_core_gnt),
        .gnt1 (w_dbg_gnt)
    );

    assign boot_gnt = w_boot_gnt;
    assign core_gnt = w_core_gnt;
    assign dbg_gnt  = w_dbg_gnt;

    // RAM mux follows the winner; the address parks on its last value.
    always_comb begin
        w_owner   = OWN_NONE;
        ram_we    = 1'b0;
        ram_addr  = r_addr_hold;
        ram_wdata = '0;
        if (w_boot_gnt) begin
            w_owner   = OWN_BOOT;
            ram_we    = boot_we;
            ram_addr  = boot_addr;
            ram_wdata = boot_wdata;
        end else if (w_core_gnt) begin
            w_owner   = OWN_CORE;
            ram_we    = core_we;
            ram_addr  = core_addr;
            ram_wdata = core_wdata;
        end else if (w_dbg_gnt) begin
            w_owner   = OWN_DBG;
            ram_addr  = dbg_addr;
        end
    end

    assign core_rvalid = (r_rd_owner == OWN_CORE);
    assign dbg_rvalid  = (r_rd_owner == OWN_DBG);
    assign rdata       = (r_rd_owner != OWN_NONE) ? ram_rdata : '0;
    assign lock_err    = r_lock_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= BYPASS_BOOT ? ARB_SHARED : ARB_BOOT;
            r_lock_cnt  <= '0;
            r_lock_err  <= 1'b0;
            r_mask_core <= 1'b0;
            r_rd_owner  <= OWN_NONE;
            r_addr_hold <= '0;
        end else begin
            r_addr_hold <= ram_addr;
            r_rd_owner  <= ((w_owner != OWN_NONE) && !ram_we) ? w_owner : OWN_NONE;
            r_mask_core <= 1'b0;
            case (r_state)
                ARB_BOOT: begin
                    if (!boot_active) begin
                        r_state <= ARB_SHARED;
                    end
                end
                ARB_SHARED: begin
                    r_lock_cnt <= '0;
                    // A locking core grant beats a pending boot takeover;
                    // boot then waits until the lock is released.
                    if (w_core_gnt && core_lock) begin
                        r_state <= ARB_LOCKED;
                    end else if (boot_active && !BYPASS_BOOT) begin
                        r_state <= ARB_BOOT;
                    end
                end
                ARB_LOCKED: begin
                    if (!core_lock) begin
                        r_state    <= ARB_SHARED;
                        r_lock_cnt <= '0;
                    end else if (r_lock_cnt == c_cnt_w'(LOCK_MAX - 1)) begin
                        r_state     <= ARB_SHARED;
                        r_lock_cnt  <= '0;
                        r_lock_err  <= 1'b1;
                        r_mask_core <= 1'b1;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + c_cnt_w'(1);
                    end
                end
                default: r_state <= ARB_SHARED;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a behavioural RAM and a
//            read-data scoreboard per port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    localparam int c_lock_max = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_active, boot_req, boot_we;
    logic [9:0]  boot_addr;
    logic [15:0] boot_wdata;
    logic        boot_gnt;
    logic        core_req, core_we, core_lock;
    logic [9:0]  core_addr;
    logic [15:0] core_wdata;
    logic        core_gnt, core_rvalid;
    logic        dbg_req;
    logic [9:0]  dbg_addr;
    logic        dbg_gnt, dbg_rvalid;
    logic [15:0] rdata;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = 16'h0;
    logic        lock_err;

    mem_arbiter #(.BYPASS_BOOT(1'b0), .LOCK_MAX(c_lock_max)) dut (
        .clk         (clk),
        .rst         (rst),
        .boot_active (boot_active),
        .boot_req    (boot_req),
        .boot_we     (boot_we),
        .boot_addr   (boot_addr),
        .boot_wdata  (boot_wdata),
        .boot_gnt    (boot_gnt),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_lock   (core_lock),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .dbg_req     (dbg_req),
        .dbg_addr    (dbg_addr),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .rdata       (rdata),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .lock_err    (lock_err)
    );

    always #5 clk = ~clk;

    // Behavioural 1024x16 RAM, read-first, registered read data.
    logic [15:0] ram_mem [1024];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected read data and the cycle of the grant.
    typedef struct {
        logic [15:0] data;
        int          gcyc;
    } exp_t;
    exp_t        core_q[$];
    exp_t        dbg_q[$];
    logic [15:0] shadow [1024];
    exp_t        e;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            shadow[i]  = 16'h0;
            ram_mem[i] = 16'h0;
        end
    end

    always @(negedge clk) begin
        if (core_rvalid) begin
            if (core_q.size() == 0) chk("core_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = core_q.pop_front();
                chk("core_rdata", {16'h0, rdata}, {16'h0, e.data});
                chk("core_latency", cyc, e.gcyc + 1);
            end
        end
        if (dbg_rvalid) begin
            if (dbg_q.size() == 0) chk("dbg_rvalid_unexpected", 32'd1, 32'd0);
            else begin
                e = dbg_q.pop_front();
                chk("dbg_rdata", {16'h0, rdata}, {16'h0, e.data});
                chk("dbg_latency", cyc, e.gcyc + 1);
            end
        end
        if (core_gnt) begin
            if (core_we) shadow[core_addr] = core_wdata;
            else core_q.push_back('{shadow[core_addr], cyc});
        end
        if (dbg_gnt) dbg_q.push_back('{shadow[dbg_addr], cyc});
        if (boot_gnt && boot_we) shadow[boot_addr] = boot_wdata;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    int first_err;

    initial begin
        rst = 1'b1; boot_active = 1'b1; boot_req = 1'b0; boot_we = 1'b0;
        boot_addr = '0; boot_wdata = '0;
        core_req = 1'b1; core_we = 1'b0; core_lock = 1'b0;
        core_addr = 10'h001; core_wdata = '0;
        dbg_req = 1'b0; dbg_addr = '0;
        #2;
        chk("rst_gnts", {29'h0, boot_gnt, core_gnt, dbg_gnt}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_ram_addr", {22'h0, ram_addr}, 32'h0);
        chk("rst_rdata", {16'h0, rdata}, 32'h0);
        chk("rst_flags", {29'h0, lock_err, core_rvalid, dbg_rvalid}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Boot owns memory; core keeps requesting but is never granted.
        boot_req = 1'b1; boot_we = 1'b1; boot_addr = 10'h001; boot_wdata = 16'h2A2A;
        #1;
        chk("boot_gnt", {31'h0, boot_gnt}, 32'h1);
        chk("boot_core_gnt", {31'h0, core_gnt}, 32'h0);
        chk("boot_ram_we", {31'h0, ram_we}, 32'h1);
        chk("boot_ram_addr", {22'h0, ram_addr}, 32'h001);
        chk("boot_ram_wdata", {16'h0, ram_wdata}, 32'h2A2A);
        next_cycle();
        boot_req = 1'b0; boot_we = 1'b0; boot_active = 1'b0;
        #1;
        chk("boot_core_gnt2", {31'h0, core_gnt}, 32'h0);
        chk("idle_ram_we", {31'h0, ram_we}, 32'h0);
        chk("idle_addr_hold", {22'h0, ram_addr}, 32'h001);
        next_cycle();
        #1;
        chk("shared_core_gnt", {31'h0, core_gnt}, 32'h1);
        next_cycle();
        core_req = 1'b0;
        #1;
        chk("boot_rd_rvalid", {31'h0, core_rvalid}, 32'h1);
        chk("boot_rd_rdata", {16'h0, rdata}, 32'h2A2A);
        next_cycle();

        // Core fills 0x010..0x013.
        for (int i = 0; i < 4; i++) begin
            core_req = 1'b1; core_we = 1'b1;
            core_addr = 10'h010 + 10'(i); core_wdata = 16'h1000 + 16'(i);
            #1;
            chk("fill_core_gnt", {31'h0, core_gnt}, 32'h1);
            next_cycle();
        end

        // Continuous contention alternates; core won last, so debug first.
        core_we = 1'b0; core_addr = 10'h010; dbg_req = 1'b1; dbg_addr = 10'h011;
        for (int j = 0; j < 8; j++) begin
            #1;
            chk("rr_core_gnt", {31'h0, core_gnt}, {31'h0, j[0]});
            chk("rr_dbg_gnt", {31'h0, dbg_gnt}, {31'h0, ~j[0]});
            next_cycle();
        end

        // Lock held for 5 cycles blocks debug.
        dbg_req = 1'b0; core_lock = 1'b1; core_addr = 10'h012;
        #1;
        chk("lock_core_gnt", {31'h0, core_gnt}, 32'h1);
        next_cycle();
        dbg_req = 1'b1; dbg_addr = 10'h013;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("locked_dbg_gnt", {31'h0, dbg_gnt}, 32'h0);
            chk("locked_core_gnt", {31'h0, core_gnt}, 32'h1);
            next_cycle();
        end
        core_lock = 1'b0; core_req = 1'b0;
        #1;
        chk("unlock_dbg_gnt0", {31'h0, dbg_gnt}, 32'h0);
        next_cycle();
        #1;
        chk("unlock_dbg_gnt1", {31'h0, dbg_gnt}, 32'h1);
        next_cycle();
        chk("pre_lock_err", {31'h0, lock_err}, 32'h0);

        // Lock held past LOCK_MAX: forced release, debug gets the slot.
        core_req = 1'b1; core_lock = 1'b1; dbg_req = 1'b1;
        first_err = -1;
        for (int k = 0; k < 71; k++) begin
            #1;
            if (k == 0) chk("tmo_core_gnt0", {31'h0, core_gnt}, 32'h1);
            if (lock_err && first_err < 0) begin
                first_err = k;
                chk("tmo_dbg_gnt", {31'h0, dbg_gnt}, 32'h1);
                chk("tmo_core_masked", {31'h0, core_gnt}, 32'h0);
            end
            next_cycle();
        end
        chk("tmo_cycle", first_err, c_lock_max + 1);
        core_req = 1'b0; core_lock = 1'b0; dbg_req = 1'b0;
        repeat (3) next_cycle();
        chk("lock_err_sticky", {31'h0, lock_err}, 32'h1);

        // Write 0x3FF then read it back.
        core_req = 1'b1; core_we = 1'b1; core_addr = 10'h3FF; core_wdata = 16'h0007;
        #1;
        chk("wr_core_gnt", {31'h0, core_gnt}, 32'h1);
        chk("wr_ram_we", {31'h0, ram_we}, 32'h1);
        chk("wr_ram_addr", {22'h0, ram_addr}, 32'h3FF);
        chk("wr_ram_wdata", {16'h0, ram_wdata}, 32'h0007);
        next_cycle();
        core_we = 1'b0;
        #1;
        chk("wr_no_rvalid", {31'h0, core_rvalid}, 32'h0);
        chk("rd_core_gnt", {31'h0, core_gnt}, 32'h1);
        chk("rd_ram_we", {31'h0, ram_we}, 32'h0);
        next_cycle();
        core_req = 1'b0;
        #1;
        chk("rd_rvalid", {31'h0, core_rvalid}, 32'h1);
        chk("rd_rdata", {16'h0, rdata}, 32'h0007);
        next_cycle();

        // Reset during a granted read.
        core_req = 1'b1; core_addr = 10'h3FF;
        #1;
        chk("rstmid_gnt", {31'h0, core_gnt}, 32'h1);
        rst = 1'b1; boot_active = 1'b1;
        #1;
        chk("rstmid_gnts", {29'h0, boot_gnt, core_gnt, dbg_gnt}, 32'h0);
        chk("rstmid_ram", {21'h0, ram_we, ram_addr}, 32'h0);
        chk("rstmid_outs", {14'h0, lock_err, core_rvalid, rdata}, 32'h0);
        core_req = 1'b0;
        next_cycle();
        #1;
        chk("rstmid_no_rvalid", {31'h0, core_rvalid}, 32'h0);
        rst = 1'b0;
        core_req = 1'b1; boot_req = 1'b1; boot_we = 1'b0; boot_addr = 10'h005;
        #1;
        chk("post_rst_core_gnt", {31'h0, core_gnt}, 32'h0);
        chk("post_rst_boot_gnt", {31'h0, boot_gnt}, 32'h1);
        next_cycle();
        core_req = 1'b0; boot_req = 1'b0;
        #1;
        chk("boot_rd_no_rvalid", {30'h0, core_rvalid, dbg_rvalid}, 32'h0);
        next_cycle();
        chk("core_q_empty", core_q.size(), 32'd0);
        chk("dbg_q_empty", dbg_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
